// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the IFU (read-only) and the LSU.
// One transaction in flight; a response watchdog turns a hung access into an error response.
module mem_arbiter #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_resp_valid,
    input  logic                  ifu_resp_ready,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic                  ifu_resp_err,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wmask,
    output logic                  lsu_resp_valid,
    input  logic                  lsu_resp_ready,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  lsu_resp_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int STRB_W = DATA_W / 8;
    // Timer never needs to exceed TIMEOUT-1; with the watchdog disabled it simply wraps.
    localparam int                TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
    typedef enum logic {OWN_IFU, OWN_LSU} owner_e;

    state_e               state_q, state_d;
    owner_e               last_q, last_d;
    owner_e               owner_q, owner_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 wen_q, wen_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [STRB_W-1:0]    wmask_q, wmask_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [DATA_W-1:0]    ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;
    logic                 ifu_err_q, ifu_err_d, lsu_err_q, lsu_err_d;

    logic                 grant_ifu, grant_lsu;
    logic                 resp_load, resp_err;
    logic [DATA_W-1:0]    resp_data;
    logic                 owner_resp_ready;

    assign owner_resp_ready = (owner_q == OWN_IFU) ? ifu_resp_ready : lsu_resp_ready;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        timer_d     = timer_q;
        ifu_rdata_d = ifu_rdata_q;
        ifu_err_d   = ifu_err_q;
        lsu_rdata_d = lsu_rdata_q;
        lsu_err_d   = lsu_err_q;
        grant_ifu   = 1'b0;
        grant_lsu   = 1'b0;
        resp_load   = 1'b0;
        resp_err    = 1'b0;
        resp_data   = '0;

        case (state_q)
            IDLE: begin
                // On contention the side that did not win last time gets the port.
                if (ifu_req_valid && !(lsu_req_valid && last_q == OWN_IFU)) begin
                    grant_ifu = 1'b1;
                end else if (lsu_req_valid) begin
                    grant_lsu = 1'b1;
                end
                if (grant_ifu) begin
                    owner_d = OWN_IFU;
                    addr_d  = ifu_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                    state_d = ISSUE;
                end else if (grant_lsu) begin
                    owner_d = OWN_LSU;
                    addr_d  = lsu_addr;
                    wen_d   = lsu_wen;
                    wdata_d = lsu_wdata;
                    wmask_d = lsu_wmask;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    timer_d = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                timer_d = timer_q + 1'b1;
                if (mem_resp_valid) begin
                    resp_load = 1'b1;
                    resp_data = mem_rdata;
                    state_d   = RESP;
                end else if (TIMEOUT != 0 && timer_q == TMR_LAST) begin
                    resp_load = 1'b1;
                    resp_data = ERR_DATA;
                    resp_err  = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (owner_resp_ready) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Only the owner's response registers change; the other side keeps its last response.
        if (resp_load) begin
            if (owner_q == OWN_IFU) begin
                ifu_rdata_d = resp_data;
                ifu_err_d   = resp_err;
            end else begin
                lsu_rdata_d = resp_data;
                lsu_err_d   = resp_err;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples its pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= OWN_LSU;
            owner_q     <= OWN_IFU;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            timer_q     <= '0;
            ifu_rdata_q <= '0;
            ifu_err_q   <= 1'b0;
            lsu_rdata_q <= '0;
            lsu_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            timer_q     <= timer_d;
            ifu_rdata_q <= ifu_rdata_d;
            ifu_err_q   <= ifu_err_d;
            lsu_rdata_q <= lsu_rdata_d;
            lsu_err_q   <= lsu_err_d;
        end
    end

    assign ifu_req_ready  = grant_ifu;
    assign lsu_req_ready  = grant_lsu;
    assign mem_req_valid  = (state_q == ISSUE);
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;
    assign ifu_resp_valid = (state_q == RESP) && (owner_q == OWN_IFU);
    assign lsu_resp_valid = (state_q == RESP) && (owner_q == OWN_LSU);
    assign ifu_rdata      = ifu_rdata_q;
    assign ifu_resp_err   = ifu_err_q;
    assign lsu_rdata      = lsu_rdata_q;
    assign lsu_resp_err   = lsu_err_q;

endmodule
